obs_overlap_accum: RTL and testbench

//  Parametrised, handshaked successor of the fixed-width OBS overlap stage. Takes the four
//  GF(2) sub-products of an odd/even split multiply, interleaves them into a 2W+1-bit product
//  and XOR-accumulates products over a multi-beat transaction. Sits between the sub-multiplier

---
 rtl/obs_overlap_accum_if.sv | 33 +++
 rtl/obs_overlap_accum.sv | 175 +++++++++++++++++
 tb/tb_obs_overlap_accum.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/obs_overlap_accum_if.sv
// Beat/product handshake bundle for the OBS overlap accumulator.
// The block takes the slave side; the producer/consumer pair takes the master side.
interface obs_overlap_accum_if #(
  parameter int W         = 71,
  parameter int MAX_BEATS = 8
);
  localparam int OW = 2 * W + 1;
  localparam int CW = $clog2(MAX_BEATS + 1);

  logic          s_valid;
  logic          s_ready;
  logic          s_first;
  logic          s_last;
  logic [W-1:0]  s_in1;
  logic [W-1:0]  s_in2;
  logic [W-1:0]  s_in3;
  logic [W-1:0]  s_in4;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;
  logic [CW-1:0] m_beats;
  logic          err;

  modport slave (
    input  s_valid, s_first, s_last, s_in1, s_in2, s_in3, s_in4, m_ready,
    output s_ready, m_valid, m_data, m_beats, err
  );

  modport master (
    output s_valid, s_first, s_last, s_in1, s_in2, s_in3, s_in4, m_ready,
    input  s_ready, m_valid, m_data, m_beats, err
  );
endinterface

// File: rtl/obs_overlap_accum.sv
// OBS overlap stage: interleaves four GF(2) sub-products into a 2W+1-bit product
// and XOR-accumulates them over a multi-beat handshaked transaction.
module obs_overlap_accum #(
  parameter int W         = 71,
  parameter int MAX_BEATS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  obs_overlap_accum_if.slave   bus
);
  localparam int OW = 2 * W + 1;
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Even product bits pair in1 with the shifted in4; odd bits carry the cross terms.
  function automatic logic [OW-1:0] overlap(
    input logic [W-1:0] in1,
    input logic [W-1:0] in2,
    input logic [W-1:0] in3,
    input logic [W-1:0] in4
  );
    logic [OW-1:0] r;
    r    = {OW{1'b0}};
    r[0] = in1[0];
    for (int i = 1; i < W; i++) begin
      r[2*i] = in1[i] ^ in4[i-1];
    end
    r[2*W] = in4[W-1];
    for (int i = 0; i < W; i++) begin
      r[2*i+1] = in2[i] ^ in3[i];
    end
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [OW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          m_valid_q, m_valid_d;
  logic [OW-1:0] m_data_q, m_data_d;
  logic [CW-1:0] m_beats_q, m_beats_d;

  logic          beat_s;
  logic [OW-1:0] ov_s;

  assign ov_s   = overlap(bus.s_in1, bus.s_in2, bus.s_in3, bus.s_in4);
  assign beat_s = bus.s_valid & (state_q != ST_OUT);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= {OW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      err_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= {OW{1'b0}};
      m_beats_q <= {CW{1'b0}};
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_beats_q <= m_beats_d;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_beats_d = m_beats_q;
    if (clr) begin
      state_d   = ST_IDLE;
      acc_d     = {OW{1'b0}};
      cnt_d     = {CW{1'b0}};
      err_d     = 1'b0;
      m_valid_d = 1'b0;
      m_data_d  = {OW{1'b0}};
      m_beats_d = {CW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (beat_s) begin
            acc_d = ov_s;
            cnt_d = CW'(1);
            if (bus.s_last || (cnt_d == CW'(MAX_BEATS))) begin
              state_d   = ST_OUT;
              m_valid_d = 1'b1;
              m_data_d  = acc_d;
              m_beats_d = cnt_d;
            end else begin
              state_d = ST_ACC;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ACC: begin
          if (beat_s) begin
            // A stray s_first restarts the transaction on this beat and flags it.
            if (bus.s_first) begin
              err_d = 1'b1;
              acc_d = ov_s;
              cnt_d = CW'(1);
            end else begin
              acc_d = acc_q ^ ov_s;
              cnt_d = cnt_q + CW'(1);
            end
            if (bus.s_last || (cnt_d == CW'(MAX_BEATS))) begin
              state_d   = ST_OUT;
              m_valid_d = 1'b1;
              m_data_d  = acc_d;
              m_beats_d = cnt_d;
              if (!bus.s_last) begin
                err_d = 1'b1;
              end else begin
                err_d = err_d;
              end
            end else begin
              state_d = ST_ACC;
            end
          end else begin
            state_d = ST_ACC;
          end
        end
        ST_OUT: begin
          if (bus.m_ready) begin
            state_d   = ST_IDLE;
            acc_d     = {OW{1'b0}};
            cnt_d     = {CW{1'b0}};
            m_valid_d = 1'b0;
            m_data_d  = {OW{1'b0}};
            m_beats_d = {CW{1'b0}};
          end else begin
            state_d = ST_OUT;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          acc_d     = {OW{1'b0}};
          cnt_d     = {CW{1'b0}};
          m_valid_d = 1'b0;
          m_data_d  = {OW{1'b0}};
          m_beats_d = {CW{1'b0}};
        end
      endcase
    end
  end

  // Outputs: everything but s_ready comes straight from a flop
  always_comb begin
    if (state_q == ST_OUT) begin
      bus.s_ready = 1'b0;
    end else begin
      bus.s_ready = 1'b1;
    end
    bus.m_valid = m_valid_q;
    bus.m_data  = m_data_q;
    bus.m_beats = m_beats_q;
    bus.err     = err_q;
  end
endmodule

// File: tb/tb_obs_overlap_accum.sv
// Directed bench for obs_overlap_accum at W=4/MAX_BEATS=3, plus one beat at default W=71.
module tb_obs_overlap_accum;
  logic clk;
  logic rst_n;
  logic clr;
  int   checks_cnt;
  int   errors_cnt;

  obs_overlap_accum_if #(.W(4), .MAX_BEATS(3)) bus_a ();
  obs_overlap_accum_if #(.W(71), .MAX_BEATS(8)) bus_b ();

  obs_overlap_accum #(.W(4), .MAX_BEATS(3)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus_a)
  );

  obs_overlap_accum u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [3:0] i1, input logic [3:0] i2, input logic [3:0] i3,
                        input logic [3:0] i4, input logic first, input logic last);
    int n;
    @(negedge clk);
    bus_a.s_valid = 1'b1;
    bus_a.s_in1 = i1; bus_a.s_in2 = i2; bus_a.s_in3 = i3; bus_a.s_in4 = i4;
    bus_a.s_first = first; bus_a.s_last = last;
    n = 0;
    while (!bus_a.s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("beat_timeout", 256'd0, 256'd1);
    @(posedge clk);
    #1;
    bus_a.s_valid = 1'b0;
    bus_a.s_first = 1'b0;
    bus_a.s_last  = 1'b0;
  endtask

  task automatic drain_a();
    @(negedge clk);
    bus_a.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_a.m_ready = 1'b0;
    check("drain_valid", 256'(bus_a.m_valid), 256'd0);
    check("drain_data", 256'(bus_a.m_data), 256'd0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n = 1'b0;
    clr   = 1'b0;
    bus_a.s_valid = 1'b0; bus_a.s_first = 1'b0; bus_a.s_last = 1'b0; bus_a.m_ready = 1'b0;
    bus_a.s_in1 = 4'h0; bus_a.s_in2 = 4'h0; bus_a.s_in3 = 4'h0; bus_a.s_in4 = 4'h0;
    bus_b.s_valid = 1'b0; bus_b.s_first = 1'b0; bus_b.s_last = 1'b0; bus_b.m_ready = 1'b0;
    bus_b.s_in1 = 71'h0; bus_b.s_in2 = 71'h0; bus_b.s_in3 = 71'h0; bus_b.s_in4 = 71'h0;
    #12;
    check("rst_valid", 256'(bus_a.m_valid), 256'd0);
    check("rst_beats", 256'(bus_a.m_beats), 256'd0);
    check("rst_data", 256'(bus_a.m_data), 256'd0);
    check("rst_err", 256'(bus_a.err), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 256'(bus_a.s_ready), 256'd1);

    // single beat, then hold the output for five cycles
    send_a(4'hF, 4'h1, 4'h0, 4'h0, 1'b1, 1'b1);
    check("t1_valid", 256'(bus_a.m_valid), 256'd1);
    check("t1_data", 256'(bus_a.m_data), 256'h057);
    check("t1_beats", 256'(bus_a.m_beats), 256'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", 256'(bus_a.m_valid), 256'd1);
      check("t4_hold_data", 256'(bus_a.m_data), 256'h057);
      check("t4_hold_ready", 256'(bus_a.s_ready), 256'd0);
    end
    drain_a();
    check("t4_ready_back", 256'(bus_a.s_ready), 256'd1);

    // boundary bits
    send_a(4'h1, 4'h0, 4'h0, 4'h8, 1'b1, 1'b1);
    check("t2_edge_bits", 256'(bus_a.m_data), 256'h101);
    drain_a();
    send_a(4'h0, 4'hA, 4'hA, 4'h0, 1'b1, 1'b1);
    check("t2_cross_cancel", 256'(bus_a.m_data), 256'h000);
    check("t2_cross_valid", 256'(bus_a.m_valid), 256'd1);
    drain_a();

    // two beats cancel
    send_a(4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    check("t3_mid_valid", 256'(bus_a.m_valid), 256'd0);
    send_a(4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    check("t3_data", 256'(bus_a.m_data), 256'h000);
    check("t3_beats", 256'(bus_a.m_beats), 256'd2);
    check("t3_err", 256'(bus_a.err), 256'd0);
    drain_a();

    // overflow at MAX_BEATS without s_last
    send_a(4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    send_a(4'h2, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    check("t5_not_yet", 256'(bus_a.m_valid), 256'd0);
    send_a(4'h4, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    check("t5_ovf_valid", 256'(bus_a.m_valid), 256'd1);
    check("t5_ovf_data", 256'(bus_a.m_data), 256'h015);
    check("t5_ovf_beats", 256'(bus_a.m_beats), 256'd3);
    check("t5_ovf_err", 256'(bus_a.err), 256'd1);
    drain_a();
    check("t5_err_sticky", 256'(bus_a.err), 256'd1);
    pulse_clr();
    check("t5_clr_err", 256'(bus_a.err), 256'd0);

    // stray s_first restarts
    send_a(4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    send_a(4'h2, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    check("t5_restart_err", 256'(bus_a.err), 256'd1);
    send_a(4'h4, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    check("t5_restart_data", 256'(bus_a.m_data), 256'h014);
    check("t5_restart_beats", 256'(bus_a.m_beats), 256'd2);
    drain_a();
    pulse_clr();

    // clr during ACC, with a beat presented in the same cycle
    send_a(4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    bus_a.s_valid = 1'b1; bus_a.s_in1 = 4'h2; bus_a.s_last = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    bus_a.s_valid = 1'b0; bus_a.s_last = 1'b0;
    check("t6_clr_valid", 256'(bus_a.m_valid), 256'd0);
    check("t6_clr_beats", 256'(bus_a.m_beats), 256'd0);
    send_a(4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    check("t6_clr_after", 256'(bus_a.m_data), 256'h001);
    check("t6_clr_after_beats", 256'(bus_a.m_beats), 256'd1);
    drain_a();

    // asynchronous reset during ACC
    send_a(4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 256'(bus_a.m_valid), 256'd0);
    check("t6_rst_beats", 256'(bus_a.m_beats), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_a(4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    check("t6_rst_after", 256'(bus_a.m_data), 256'h001);

    // asynchronous reset during OUT
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 256'(bus_a.m_valid), 256'd0);
    check("t6_rst_out_data", 256'(bus_a.m_data), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // default-width instance, single beat
    @(negedge clk);
    bus_b.s_valid = 1'b1; bus_b.s_first = 1'b1; bus_b.s_last = 1'b1;
    bus_b.s_in1 = 71'hF; bus_b.s_in2 = 71'h1;
    @(posedge clk);
    #1;
    bus_b.s_valid = 1'b0;
    check("w71_valid", 256'(bus_b.m_valid), 256'd1);
    check("w71_data", 256'(bus_b.m_data), 256'h057);
    check("w71_beats", 256'(bus_b.m_beats), 256'd1);
    @(negedge clk);
    bus_b.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_b.m_ready = 1'b0;
    check("w71_drain", 256'(bus_b.m_valid), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
